// File: rtl/jk_seq_ctrl_if.sv
// Command handshake between the datapath and the jk_seq_ctrl sequencer.
// The master issues CLEAR/LOAD/UP/DOWN commands; the slave accepts them when ready.
interface jk_seq_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_arg;

  modport master (output cmd_valid, cmd_op, cmd_arg, input cmd_ready);
  modport slave  (input cmd_valid, cmd_op, cmd_arg, output cmd_ready);
endinterface

// File: rtl/jk_seq_ctrl.sv
// Sequencer for an external bank of JK cells (JK: 00 hold, 01 clear, 10 toggle, 11 set).
// Runs CLEAR/LOAD in one APPLY cycle, and n-step UP/DOWN counts in RUN.
module jk_seq_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  jk_seq_ctrl_if.slave     cmd,
  input  logic             abort,
  input  logic [WIDTH-1:0] q_in,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out,
  output logic             busy,
  output logic             done,
  output logic             tc,
  output logic             wrapped
);

  typedef enum logic [1:0] {
    OP_CLEAR = 2'b00,
    OP_LOAD  = 2'b01,
    OP_UP    = 2'b10,
    OP_DOWN  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_APPLY,
    S_RUN,
    S_DONE
  } state_e;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_e           state;
  op_e              op;
  logic [WIDTH-1:0] arg;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] up_en;
  logic [WIDTH-1:0] dn_en;

  // Per-bit toggle enables: bit i flips when all lower bits are ones (up) or zeros (down).
  always_comb begin
    logic ones_below;
    logic zeros_below;
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    ones_below  = 1'b1;
    zeros_below = 1'b1;
    up_en       = '0;
    dn_en       = '0;
    for (int i = 0; i < WIDTH; i++) begin
      up_en[i]    = ones_below;
      dn_en[i]    = zeros_below;
      ones_below  = ones_below & q_in[i];
      zeros_below = zeros_below & ~q_in[i];
    end
  end

  assign tc = (state == S_RUN) && !abort &&
              ((op == OP_UP) ? (&q_in) : ~(|q_in));

  // Excitation depends only on state, latched command, Q_IN and ABORT.
  always_comb begin
    j_out = '0;
    k_out = '0;
    case (state)
      S_APPLY: begin
        k_out = '1;
        if (op == OP_LOAD) j_out = arg;
      end
      S_RUN: begin
        if (!abort) j_out = (op == OP_UP) ? up_en : dn_en;
      end
      default: ;
    endcase
  end

  assign cmd.cmd_ready = (state == S_IDLE);
  assign busy          = (state == S_APPLY) || (state == S_RUN);
  assign done          = (state == S_DONE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      op      <= OP_CLEAR;
      arg     <= '0;
      count   <= '0;
      wrapped <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd.cmd_valid) begin
            op      <= op_e'(cmd.cmd_op);
            arg     <= cmd.cmd_arg;
            wrapped <= 1'b0;
            if (cmd.cmd_op == OP_CLEAR || cmd.cmd_op == OP_LOAD) begin
              state <= S_APPLY;
            end else if (cmd.cmd_arg != '0) begin
              count <= cmd.cmd_arg;
              state <= S_RUN;
            end else begin
              state <= S_DONE;
            end
          end
        end
        S_APPLY: state <= S_DONE;
        S_RUN: begin
          if (abort) begin
            state <= S_DONE;
          end else begin
            if (tc) wrapped <= 1'b1;
            count <= count - ONE;
            if (count == ONE) state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jk_seq_ctrl.sv
// Directed bench for jk_seq_ctrl driving a behavioural 4-bit JK bank.
// Command table plus hand sequences for TC timing, abort and mid-run reset.
module tb_jk_seq_ctrl;

  localparam logic [1:0] OP_CLEAR = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_UP    = 2'b10;
  localparam logic [1:0] OP_DOWN  = 2'b11;

  logic       clk = 1'b0;
  logic       rst;
  logic       abort;
  logic [3:0] bank = 4'h0;
  logic [3:0] j_out, k_out;
  logic       busy, done, tc, wrapped;
  int         checks = 0;
  int         errors = 0;

  jk_seq_ctrl_if #(.WIDTH(4)) cmd_if ();

  jk_seq_ctrl #(.WIDTH(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .cmd     (cmd_if),
    .abort   (abort),
    .q_in    (bank),
    .j_out   (j_out),
    .k_out   (k_out),
    .busy    (busy),
    .done    (done),
    .tc      (tc),
    .wrapped (wrapped)
  );

  always #5 clk = ~clk;

  // Bank of JK cells: 00 hold, 01 clear, 10 toggle, 11 set.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      case ({j_out[i], k_out[i]})
        2'b01:   bank[i] <= 1'b0;
        2'b10:   bank[i] <= ~bank[i];
        2'b11:   bank[i] <= 1'b1;
        default: bank[i] <= bank[i];
      endcase
    end
  end

  typedef struct {
    logic [1:0] op;
    logic [3:0] arg;
    logic [3:0] exp_q;
    logic       exp_wrapped;
    int         exp_lat;
    int         exp_busy;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Issue one command from IDLE and return at the first negedge where DONE is high.
  task automatic do_cmd(input logic [1:0] op, input logic [3:0] arg,
                        output int lat, output int busy_n);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_arg   = arg;
    @(posedge clk);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    lat    = 0;
    busy_n = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) busy_n++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [3:0] arg);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_arg   = arg;
    @(posedge clk);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
  endtask

  initial begin
    int lat, busy_n;
    logic [3:0] exp_j  [3] = '{4'h1, 4'hF, 4'h1};
    logic       exp_tc [3] = '{1'b0, 1'b1, 1'b0};

    vecs[0]  = '{OP_LOAD,  4'hA, 4'hA, 1'b0, 1,  1};
    vecs[1]  = '{OP_CLEAR, 4'hF, 4'h0, 1'b0, 1,  1};
    vecs[2]  = '{OP_LOAD,  4'hE, 4'hE, 1'b0, 1,  1};
    vecs[3]  = '{OP_UP,    4'h3, 4'h1, 1'b1, 3,  3};
    vecs[4]  = '{OP_LOAD,  4'h0, 4'h0, 1'b0, 1,  1};
    vecs[5]  = '{OP_DOWN,  4'h2, 4'hE, 1'b1, 2,  2};
    vecs[6]  = '{OP_LOAD,  4'h5, 4'h5, 1'b0, 1,  1};
    vecs[7]  = '{OP_UP,    4'h0, 4'h5, 1'b0, 0,  0};
    vecs[8]  = '{OP_DOWN,  4'h1, 4'h4, 1'b0, 1,  1};
    vecs[9]  = '{OP_UP,    4'hF, 4'h3, 1'b1, 15, 15};
    vecs[10] = '{OP_DOWN,  4'h4, 4'hF, 1'b1, 4,  4};
    vecs[11] = '{OP_LOAD,  4'h7, 4'h7, 1'b0, 1,  1};
    vecs[12] = '{OP_UP,    4'h8, 4'hF, 1'b0, 8,  8};
    vecs[13] = '{OP_DOWN,  4'h0, 4'hF, 1'b0, 0,  0};

    rst              = 1'b1;
    abort            = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = 2'b00;
    cmd_if.cmd_arg   = 4'h0;

    #2;
    check("rst_ready",   32'(cmd_if.cmd_ready), 1);
    check("rst_busy",    32'(busy), 0);
    check("rst_done",    32'(done), 0);
    check("rst_tc",      32'(tc), 0);
    check("rst_wrapped", 32'(wrapped), 0);
    check("rst_j",       32'(j_out), 0);
    check("rst_k",       32'(k_out), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Table of back-to-back commands; each row starts from the previous row's bank value.
    for (int v = 0; v < 14; v++) begin
      do_cmd(vecs[v].op, vecs[v].arg, lat, busy_n);
      check($sformatf("v%0d_latency", v), 32'(lat), 32'(vecs[v].exp_lat));
      check($sformatf("v%0d_busy_cycles", v), 32'(busy_n), 32'(vecs[v].exp_busy));
      check($sformatf("v%0d_q", v), 32'(bank), 32'(vecs[v].exp_q));
      check($sformatf("v%0d_wrapped", v), 32'(wrapped), 32'(vecs[v].exp_wrapped));
      check($sformatf("v%0d_jk_in_done", v), 32'({j_out, k_out}), 0);
      @(negedge clk);
      check($sformatf("v%0d_ready_after", v), 32'(cmd_if.cmd_ready), 1);
      check($sformatf("v%0d_done_width", v), 32'(done), 0);
    end

    // TC and excitation per RUN cycle: LOAD E then UP 3 sees Q_IN = E, F, 0.
    do_cmd(OP_LOAD, 4'hE, lat, busy_n);
    issue(OP_UP, 4'h3);
    for (int c = 0; c < 3; c++) begin
      check($sformatf("tc_run%0d", c), 32'(tc), 32'(exp_tc[c]));
      check($sformatf("j_run%0d", c), 32'(j_out), 32'(exp_j[c]));
      check($sformatf("k_run%0d", c), 32'(k_out), 0);
      check($sformatf("ready_run%0d", c), 32'(cmd_if.cmd_ready), 0);
      @(negedge clk);
    end
    check("tc_seq_done", 32'(done), 1);
    check("tc_seq_q", 32'(bank), 32'h1);
    check("tc_seq_wrapped", 32'(wrapped), 1);
    @(negedge clk);

    // Abort in the 4th RUN cycle of UP 10 from 0; a LOAD offered mid-run must be ignored.
    do_cmd(OP_LOAD, 4'h0, lat, busy_n);
    issue(OP_UP, 4'hA);
    for (int c = 0; c < 3; c++) begin
      check($sformatf("abort_q%0d", c), 32'(bank), 32'(c));
      cmd_if.cmd_valid = (c == 1);
      cmd_if.cmd_op    = OP_LOAD;
      cmd_if.cmd_arg   = 4'h9;
      @(negedge clk);
    end
    cmd_if.cmd_valid = 1'b0;
    abort = 1'b1;
    #1;
    check("abort_j", 32'(j_out), 0);
    check("abort_k", 32'(k_out), 0);
    check("abort_busy", 32'(busy), 1);
    @(negedge clk);
    abort = 1'b0;
    check("abort_done", 32'(done), 1);
    check("abort_q_final", 32'(bank), 32'h3);
    @(negedge clk);
    check("abort_ready", 32'(cmd_if.cmd_ready), 1);

    // Abort on the step that would wrap: no update and WRAPPED stays clear.
    do_cmd(OP_LOAD, 4'hF, lat, busy_n);
    issue(OP_UP, 4'h2);
    abort = 1'b1;
    #1;
    check("abort_wrap_tc", 32'(tc), 0);
    @(negedge clk);
    abort = 1'b0;
    check("abort_wrap_done", 32'(done), 1);
    check("abort_wrap_q", 32'(bank), 32'hF);
    check("abort_wrap_wrapped", 32'(wrapped), 0);
    @(negedge clk);

    // Reset mid-RUN of UP 8 from E, after the wrap has already been recorded.
    do_cmd(OP_LOAD, 4'hE, lat, busy_n);
    issue(OP_UP, 4'h8);
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_wrapped", 32'(wrapped), 1);
    rst = 1'b1;
    #1;
    check("mid_rst_j", 32'(j_out), 0);
    check("mid_rst_k", 32'(k_out), 0);
    check("mid_rst_ready", 32'(cmd_if.cmd_ready), 1);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_wrapped", 32'(wrapped), 0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check($sformatf("mid_rst_done%0d", c), 32'(done), 0);
      check($sformatf("mid_rst_q%0d", c), 32'(bank), 32'h0);
    end
    rst = 1'b0;
    // ABORT held through a LOAD must not affect APPLY.
    abort = 1'b1;
    do_cmd(OP_LOAD, 4'h6, lat, busy_n);
    abort = 1'b0;
    check("post_rst_lat", 32'(lat), 1);
    check("post_rst_q", 32'(bank), 32'h6);
    @(negedge clk);
    check("post_rst_ready", 32'(cmd_if.cmd_ready), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
